// File: rtl/ray_tracer.sv
// Orthographic fixed-point ray caster: one ray per pixel along -Z, one triangle per cycle.
// Define RAYTRACER_CULL_EN to drop clockwise (back-facing) triangles.
module ray_tracer #(
    parameter int W    = 16,
    parameter int NTRI = 12,
    parameter int HRES = 8,
    parameter int VRES = 8,
    parameter int STEP = 16'h0100
) (
    input  logic                        sysclk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic                        tri_we,
    input  logic [$clog2(NTRI)-1:0]     tri_addr,
    input  logic [7*W+23:0]             tri_data,
    input  logic [$clog2(NTRI+1)-1:0]   tri_count,
    input  logic [23:0]                 fill_color,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic [$clog2(HRES)-1:0]     pix_x,
    output logic [$clog2(VRES)-1:0]     pix_y,
    output logic [23:0]                 pix_color,
    output logic                        update
);
    localparam int XW = $clog2(HRES);
    localparam int YW = $clog2(VRES);
    localparam int AW = $clog2(NTRI);
    localparam int CW = $clog2(NTRI + 1);
    localparam int DW = 7 * W + 24;
    localparam int EW = 2 * W + 2;

    typedef enum logic [1:0] {IDLE, TRACE, EMIT} state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       n_q, n_d;
    logic [23:0]         fill_q, fill_d;
    logic                best_hit_q, best_hit_d;
    logic signed [W-1:0] best_z_q, best_z_d;
    logic [23:0]         best_col_q, best_col_d;
    logic                valid_q, valid_d;
    logic [23:0]         color_q, color_d;
    logic                update_q, update_d;

    logic [DW-1:0]       mem_q [NTRI];
    logic [DW-1:0]       ent;
    logic signed [W-1:0] x0, y0, x1, y1, x2, y2, tz, wx, wy;
    logic [23:0]         tcol;
    logic signed [EW-1:0] e0, e1, e2;
    logic                pos, neg, nz, hit, take, last;

    always_ff @(posedge sysclk) begin
        if (tri_we && state_q == IDLE) mem_q[tri_addr] <= tri_data;
    end

    function automatic logic signed [EW-1:0] edge_fn(
        input logic signed [W-1:0] ax, ay, bx, by, px, py);
        logic signed [W:0] dbx, dby, dpx, dpy;
        dbx = (W+1)'(bx) - (W+1)'(ax);
        dby = (W+1)'(by) - (W+1)'(ay);
        dpx = (W+1)'(px) - (W+1)'(ax);
        dpy = (W+1)'(py) - (W+1)'(ay);
        return EW'(dbx) * EW'(dpy) - EW'(dby) * EW'(dpx);
    endfunction

    assign ent  = mem_q[idx_q];
    assign x0   = ent[DW-1 -: W];
    assign y0   = ent[DW-1-W -: W];
    assign x1   = ent[DW-1-2*W -: W];
    assign y1   = ent[DW-1-3*W -: W];
    assign x2   = ent[DW-1-4*W -: W];
    assign y2   = ent[DW-1-5*W -: W];
    assign tz   = ent[DW-1-6*W -: W];
    assign tcol = ent[23:0];

    // Pixel centres, row 0 at the top of the screen
    assign wx = W'((int'(x_q) - HRES / 2) * STEP + STEP / 2);
    assign wy = W'((VRES / 2 - 1 - int'(y_q)) * STEP + STEP / 2);

    assign e0 = edge_fn(x0, y0, x1, y1, wx, wy);
    assign e1 = edge_fn(x1, y1, x2, y2, wx, wy);
    assign e2 = edge_fn(x2, y2, x0, y0, wx, wy);

    assign pos = (e0 >= 0) && (e1 >= 0) && (e2 >= 0);
    assign neg = (e0 <= 0) && (e1 <= 0) && (e2 <= 0);
    assign nz  = (e0 != 0) || (e1 != 0) || (e2 != 0);
`ifdef RAYTRACER_CULL_EN
    assign hit = pos && nz;
`else
    assign hit = (pos || neg) && nz;
`endif
    assign take = hit && (n_q != '0) && (!best_hit_q || tz > best_z_q);
    assign last = (int'(idx_q) + 1 >= int'(n_q));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        idx_d      = idx_q;
        n_d        = n_q;
        fill_d     = fill_q;
        best_hit_d = best_hit_q;
        best_z_d   = best_z_q;
        best_col_d = best_col_q;
        valid_d    = valid_q;
        color_d    = color_q;
        update_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d    = TRACE;
                    n_d        = tri_count;
                    fill_d     = fill_color;
                    x_d        = '0;
                    y_d        = '0;
                    idx_d      = '0;
                    best_hit_d = 1'b0;
                end
            end
            TRACE: begin
                if (take) begin
                    best_hit_d = 1'b1;
                    best_z_d   = tz;
                    best_col_d = tcol;
                end
                if (last) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                    color_d = best_hit_d ? best_col_d : fill_q;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            EMIT: begin
                if (pix_ready) begin
                    valid_d    = 1'b0;
                    idx_d      = '0;
                    best_hit_d = 1'b0;
                    state_d    = TRACE;
                    if (x_q == XW'(HRES - 1)) begin
                        x_d = '0;
                        if (y_q == YW'(VRES - 1)) begin
                            y_d      = '0;
                            state_d  = IDLE;
                            update_d = 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            idx_q      <= '0;
            n_q        <= '0;
            fill_q     <= '0;
            best_hit_q <= 1'b0;
            best_z_q   <= '0;
            best_col_q <= '0;
            valid_q    <= 1'b0;
            color_q    <= '0;
            update_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            fill_q     <= fill_d;
            best_hit_q <= best_hit_d;
            best_z_q   <= best_z_d;
            best_col_q <= best_col_d;
            valid_q    <= valid_d;
            color_q    <= color_d;
            update_q   <= update_d;
        end
    end

    assign pix_valid = valid_q;
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign pix_color = color_q;
    assign update    = update_q;
endmodule

// File: tb/tb_ray_tracer.sv
// Bench for ray_tracer: directed scenes plus random triangle lists against a
// pixel-by-pixel reference renderer.
module tb_ray_tracer;
    localparam int W    = 16;
    localparam int NTRI = 12;
    localparam int HRES = 8;
    localparam int VRES = 8;
    localparam int STEP = 256;

    logic           sysclk = 1'b0;
    logic           rst_n, run, tri_we, pix_ready;
    logic [3:0]     tri_addr;
    logic [7*W+23:0] tri_data;
    logic [3:0]     tri_count;
    logic [23:0]    fill_color;
    logic           pix_valid, update;
    logic [2:0]     pix_x, pix_y;
    logic [23:0]    pix_color;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          tx0[NTRI], ty0[NTRI], tx1[NTRI], ty1[NTRI], tx2[NTRI], ty2[NTRI], tz[NTRI];
    logic [23:0] tcol[NTRI];
    int          mdl_n;
    logic [23:0] mdl_fill;
    logic [23:0] got[64];

    ray_tracer dut (
        .sysclk(sysclk), .rst_n(rst_n), .run(run), .tri_we(tri_we),
        .tri_addr(tri_addr), .tri_data(tri_data), .tri_count(tri_count),
        .fill_color(fill_color), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .update(update)
    );

    initial forever #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint ed(longint ax, longint ay, longint bx, longint by,
                                  longint px, longint py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    // Nearest (largest z) hit triangle colour; earliest index wins ties
    function automatic logic [23:0] model(int px, int py);
        longint wx, wy, a, b, c, bz;
        bit found, ok;
        logic [23:0] col;
        wx = longint'((px - HRES / 2) * STEP + STEP / 2);
        wy = longint'((VRES / 2 - 1 - py) * STEP + STEP / 2);
        found = 0;
        bz = 0;
        col = mdl_fill;
        for (int t = 0; t < mdl_n; t++) begin
            a = ed(tx0[t], ty0[t], tx1[t], ty1[t], wx, wy);
            b = ed(tx1[t], ty1[t], tx2[t], ty2[t], wx, wy);
            c = ed(tx2[t], ty2[t], tx0[t], ty0[t], wx, wy);
`ifdef RAYTRACER_CULL_EN
            ok = (a >= 0 && b >= 0 && c >= 0);
`else
            ok = (a >= 0 && b >= 0 && c >= 0) || (a <= 0 && b <= 0 && c <= 0);
`endif
            ok = ok && !(a == 0 && b == 0 && c == 0);
            if (ok && (!found || tz[t] > bz)) begin
                found = 1;
                bz = tz[t];
                col = tcol[t];
            end
        end
        return col;
    endfunction

    task automatic wr(input int a, input int x0, input int y0, input int x1, input int y1,
                      input int x2, input int y2, input int z, input logic [23:0] c);
        tri_we = 1;
        tri_addr = 4'(a);
        tri_data = {16'(x0), 16'(y0), 16'(x1), 16'(y1), 16'(x2), 16'(y2), 16'(z), c};
        tick();
        tri_we = 0;
        tx0[a] = int'($signed(16'(x0)));
        ty0[a] = int'($signed(16'(y0)));
        tx1[a] = int'($signed(16'(x1)));
        ty1[a] = int'($signed(16'(y1)));
        tx2[a] = int'($signed(16'(x2)));
        ty2[a] = int'($signed(16'(y2)));
        tz[a]  = int'($signed(16'(z)));
        tcol[a] = c;
    endtask

    task automatic set_scene(input int n, input logic [23:0] f);
        mdl_n = n;
        mdl_fill = f;
        tri_count = 4'(n);
        fill_color = f;
    endtask

    // mode 0: ready high, 1: random ready, 2: stall 10 cycles at pixel (3,2)
    task automatic run_frame(input int mode, input bit poke);
        int k, guard, upd, start, last_hs, hold, n1;
        logic [23:0] ec;
        k = 0; guard = 0; upd = 0; last_hs = -1; hold = 0;
        n1 = (mdl_n == 0) ? 1 : mdl_n;
        run = 1;
        pix_ready = 1;
        start = cyc;
        tick();
        run = 0;
        while (k < 64 && guard < 20000) begin
            if (mode == 1) pix_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2) begin
                if (pix_valid && k == 19 && hold < 10) begin
                    pix_ready = 0;
                    hold++;
                end else pix_ready = 1;
            end
            if (update) upd++;
            if (pix_valid) begin
                ec = model(k % HRES, k / HRES);
                chk("pix_x", pix_x, k % HRES);
                chk("pix_y", pix_y, k / HRES);
                chk("pix_color", pix_color, ec);
                got[k] = pix_color;
                if (mode == 0 && k == 0) chk("first_latency", cyc - start, n1 + 1);
                if (pix_ready) begin
                    if (mode == 0 && last_hs >= 0) chk("spacing", cyc - last_hs, n1 + 1);
                    last_hs = cyc;
                    k++;
                end
            end else if (mode == 2 && hold > 0 && hold < 10) begin
                chk("stall_valid", pix_valid, 1);
            end
            tri_we = poke && !pix_valid && k == 5;
            tri_addr = 0;
            tri_data = {16'(-4096), 16'(-4096), 16'(12288), 16'(-4096),
                        16'(-4096), 16'(12288), 16'(32767), 24'h123456};
            tick();
            tri_we = 0;
            guard++;
        end
        chk("frame_pixels", k, 64);
        chk("early_update", upd, 0);
        chk("update_pulse", update, 1);
        chk("idle_valid", pix_valid, 0);
        if (mode == 2) chk("stall_cycles", hold, 10);
        tick();
        chk("update_drop", update, 0);
    endtask

    initial begin
        int n;
        rst_n = 0; run = 1; tri_we = 0; tri_addr = 0; tri_data = '0;
        pix_ready = 1;
        set_scene(0, 24'hFF0000);
        tick();
        tick();
        chk("rst_valid", pix_valid, 0);
        chk("rst_update", update, 0);
        chk("rst_x", pix_x, 0);
        chk("rst_y", pix_y, 0);
        rst_n = 1;
        tick();
        chk("rst_trace_valid", pix_valid, 0);
        tick();
        chk("rst_first_emit", pix_valid, 1);
        chk("rst_first_color", pix_color, 24'hFF0000);
        rst_n = 0; run = 0;
        tick();
        chk("abort_valid", pix_valid, 0);
        chk("abort_update", update, 0);
        rst_n = 1;
        tick();

        run_frame(0, 0);
        chk("empty_last", got[63], 24'hFF0000);

        wr(0, -1024, -1024, 1024, -1024, -1024, 1024, -1280, 24'h0096FA);
        set_scene(1, 24'h202020);
        run_frame(0, 0);
        chk("ccw_hit_0_7", got[56], 24'h0096FA);
        chk("ccw_miss_7_0", got[7], 24'h202020);

        wr(0, -4096, -4096, 12288, -4096, -4096, 12288, -1280, 24'h00FF00);
        wr(1, -4096, -4096, 12288, -4096, -4096, 12288, -768, 24'h0000FF);
        set_scene(2, 24'h000000);
        run_frame(0, 0);
        chk("depth_near", got[27], 24'h0000FF);
        wr(1, -4096, -4096, 12288, -4096, -4096, 12288, -1280, 24'h0000FF);
        run_frame(2, 0);
        chk("depth_tie", got[27], 24'h00FF00);

        wr(0, -1024, -1024, -1024, 1024, 1024, -1024, -1280, 24'h0096FA);
        set_scene(1, 24'h202020);
        run_frame(1, 1);
`ifdef RAYTRACER_CULL_EN
        chk("cw_culled", got[56], 24'h202020);
`else
        chk("cw_visible", got[56], 24'h0096FA);
`endif

        for (int s = 0; s < 4; s++) begin
            n = (s == 0) ? NTRI : int'($urandom_range(1, NTRI));
            for (int t = 0; t < n; t++) begin
                if (s == 3)
                    wr(t, int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                       int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                       int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                       int'($urandom_range(0, 3)), 24'($urandom));
                else if (s == 0 && t == 3)
                    wr(t, -512, -512, 0, 0, 512, 512, 100, 24'hABCDEF);
                else
                    wr(t, int'($urandom_range(0, 2560)) - 1280, int'($urandom_range(0, 2560)) - 1280,
                       int'($urandom_range(0, 2560)) - 1280, int'($urandom_range(0, 2560)) - 1280,
                       int'($urandom_range(0, 2560)) - 1280, int'($urandom_range(0, 2560)) - 1280,
                       int'($urandom_range(0, 3)) - 1, 24'($urandom));
            end
            set_scene(n, 24'($urandom));
            run_frame((s == 0) ? 0 : 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
